vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Full VGA raster timing generator: horizontal and vertical counters, sync pulses, data-enable, pixel coordinates and frame/line strobes.
- All timing and polarities are parametrised, so one block covers any standard mode.
- Runs off the system clock with a pixel-enable tick, so a 25 MHz pixel rate can come from a 50 MHz clock without a separate clock domain.
- Sits between the clock/tick divider and the framebuffer read / pixel pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- H_POL, 0, hsync active level
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- V_POL, 0, vsync active level
- Derived (localparam): H_TOTAL = sum of the four H terms; V_TOTAL likewise; H_W = $clog2(H_TOTAL); V_W = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel tick; the raster advances only on cycles where it is 1
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- de  out  1  inside visible area
- x  out  H_W  pixel column while de=1, else 0
- y  out  V_W  pixel row while de=1, else 0
- line_start  out  1  one-clk strobe at column 0 of every line
- frame_start  out  1  one-clk strobe at position (0,0)

Behaviour:
- Clocking: reset is rst, synchronous, active-high; clock is clk. All state and outputs are registered; there are no combinational paths from inputs to outputs.
- Reset:
  - Counters: hc=0, vc=0.
  - Outputs: hsync=~H_POL, vsync=~V_POL, de=0, x=0, y=0, line_start=0, frame_start=0.
  - Reset has priority over pix_en. Reset mid-frame restarts at (0,0) on the next tick.
- Tick (pix_en=1 on a clk edge):
  - Outputs register the decode of the current (hc,vc).
  - In the same edge, the counters advance.
  - Result: outputs lag the counters by exactly one tick and describe position (hc,vc).
- Advance rule:
  - hc increments each tick.
  - At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with hc==H_TOTAL-1, both wrap to 0.
- Decode:
  - hsync=H_POL iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync=V_POL iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC. Whole-line granularity; vsync changes only with the output for hc=0.
  - de = (hc<H_ACTIVE) && (vc<V_ACTIVE).
  - x=hc, y=vc when de=1, else x=0, y=0.
- Strobes:
  - line_start=1 for the tick with hc==0, on every line including blanking lines.
  - frame_start=1 for the tick with hc==0 and vc==0.
  - Each strobe is high for exactly one clk cycle, then clears on the next clk regardless of pix_en.
- Hold: on clk edges with pix_en=0, the counters, hsync, vsync, de, x and y hold their values; the strobes are 0.
- First tick after reset outputs (0,0): de=1, x=0, y=0, line_start=1, frame_start=1.
- Periods: line = H_TOTAL ticks, frame = H_TOTAL*V_TOTAL ticks.
- Elaboration checks (assertions): every timing parameter >=1; H_POL and V_POL in {0,1}.

Decomposition:
- vga_pkg holds:
  - Mode constants: 640x480@60 (defaults above) and 800x600@60 (800/40/128/88, 600/1/4/23, positive polarities).
  - typedef struct vga_timing_t, bundling active/fp/sync/bp/pol for one axis.
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical). Each instance provides:
  - Parametrised by one axis's timing.
  - Inputs: step (advance) enable.
  - Outputs: count, wrap flag, sync-active flag and active-region flag.
- The top level:
  - Chains the vertical step to the horizontal wrap.
  - Owns the registered output stage and the strobes.

Test Plan:
- Reset then pix_en=1 constantly, defaults → first tick de=1, x=0, y=0, frame_start=1; line_start every 800 ticks; frame_start every 420000 ticks.
- One line, defaults → de=1 for 640 consecutive ticks (x 0..639); hsync=0 exactly for the ticks decoding hc 656..751 (96 ticks); hsync=1 elsewhere.
- One frame → vsync=0 only during lines 490..491 (1600 ticks); de=0 throughout lines 480..524; y counts 0..479.
- pix_en toggling 1,0,1,0 (50 MHz clk for a 25 MHz raster) → counters and outputs hold on idle cycles; strobes are 1 clk wide; line period is 1600 clks.
- Assert rst for one clk at position (300,200) → next clk shows reset values; next tick outputs (0,0) with frame_start=1.
- Instantiate the 800x600 pkg mode with H_POL=V_POL=1 → hsync=1 for ticks decoding hc 840..967; line period 1056 ticks; frame period 1056*628 ticks.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   vga_timing_t  - timing of one raster axis (active/fp/sync/bp/polarity)
//   VGA_*         - ready-made axis timings for 640x480@60 and 800x600@60
//   vga_total()   - full period of one axis (active + fp + sync + bp)
// ---------------------------------------------------------------------------
package vga_pkg;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
      int pol;
   } vga_timing_t;

   // 640x480@60, negative sync polarities
   localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 0};
   localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 0};

   // 800x600@60, positive sync polarities
   localparam vga_timing_t VGA_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1};
   localparam vga_timing_t VGA_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1};

   function automatic int vga_total(vga_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle between the timing generator and its consumers.
//   pix_en       pixel tick into the generator
//   hsync/vsync  sync pulses (polarity set by the generator parameters)
//   de           visible-area flag
//   x/y          pixel coordinates while de=1, else 0
//   line_start   one-clk strobe at column 0 of every line
//   frame_start  one-clk strobe at position (0,0)
// master: the timing generator; slave: the consumer / tick source.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
   parameter int H_W = 10,
   parameter int V_W = 10
);
   logic           pix_en;
   logic           hsync;
   logic           vsync;
   logic           de;
   logic [H_W-1:0] x;
   logic [V_W-1:0] y;
   logic           line_start;
   logic           frame_start;

   modport master (
      input  pix_en,
      output hsync, vsync, de, x, y, line_start, frame_start
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, de, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// Position counter for one raster axis (horizontal or vertical).
//   clk, rst  clock and synchronous active-high reset
//   step      advance the count by one (wraps after the last position)
//   count     current position, 0 .. total-1
//   wrap      count sits on the last position of the axis
//   sync_act  count lies inside the sync pulse window
//   active    count lies inside the visible region
// ---------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter vga_timing_t T = VGA_640X480_H,
   parameter int          W = $clog2(vga_total(T))
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         sync_act,
   output logic         active
);

   localparam logic [W-1:0] LAST      = W'(vga_total(T) - 1);
   localparam logic [W-1:0] ACT_END   = W'(T.active);
   localparam logic [W-1:0] SYNC_BEG  = W'(T.active + T.fp);
   // back porch is at least one position, so the end of sync still fits in W
   localparam logic [W-1:0] SYNC_END  = W'(T.active + T.fp + T.sync);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

   assign count    = cnt;
   assign wrap     = (cnt == LAST);
   assign sync_act = (cnt >= SYNC_BEG) && (cnt < SYNC_END);
   assign active   = (cnt < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator driven by a pixel-enable tick on the system
// clock. Every output is registered and describes the raster position the
// counters held on the tick that produced it, so outputs trail the counters
// by exactly one tick.
//   clk  system clock
//   rst  synchronous active-high reset (priority over pix_en)
//   vif  master side of vga_timing_gen_if: pix_en in; hsync, vsync, de,
//        x, y, line_start, frame_start out
// ---------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_POL    = 0,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_POL    = 0
) (
   input  logic              clk,
   input  logic              rst,
   vga_timing_gen_if.master  vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: H_POL};
   localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: V_POL};

   localparam logic H_ON = (H_POL != 0);
   localparam logic V_ON = (V_POL != 0);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be at least 1");
   end

   if ((H_POL != 0 && H_POL != 1) || (V_POL != 0 && V_POL != 1)) begin : g_bad_pol
      $error("vga_timing_gen: H_POL and V_POL must be 0 or 1");
   end

   logic [H_W-1:0] hc;
   logic [V_W-1:0] vc;
   logic           h_wrap, h_sync, h_act;
   logic           v_wrap, v_sync, v_act;

   vga_axis_counter #(.T(H_T), .W(H_W)) u_hcnt (
      .clk      (clk),
      .rst      (rst),
      .step     (vif.pix_en),
      .count    (hc),
      .wrap     (h_wrap),
      .sync_act (h_sync),
      .active   (h_act)
   );

   // vertical axis advances only on the tick that wraps the line
   vga_axis_counter #(.T(V_T), .W(V_W)) u_vcnt (
      .clk      (clk),
      .rst      (rst),
      .step     (vif.pix_en & h_wrap),
      .count    (vc),
      .wrap     (v_wrap),
      .sync_act (v_sync),
      .active   (v_act)
   );

   // sol/sof track "counters sit at column 0" / "counters sit at (0,0)",
   // rebuilt from the wrap flags so no separate compare against zero is needed
   logic           sol, sof;
   logic           hsync_p0, vsync_p0, de_p0, line_start_p0, frame_start_p0;
   logic [H_W-1:0] x_p0;
   logic [V_W-1:0] y_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         sol <= 1'b1;
         sof <= 1'b1;
      end else if (vif.pix_en) begin
         sol <= h_wrap;
         sof <= h_wrap & v_wrap;
      end
   end

   // ---- output register stage: decode of (hc,vc) captured on each tick ----
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_p0       <= ~H_ON;
         vsync_p0       <= ~V_ON;
         de_p0          <= 1'b0;
         x_p0           <= '0;
         y_p0           <= '0;
         line_start_p0  <= 1'b0;
         frame_start_p0 <= 1'b0;
      end else begin
         // strobes last one clk whether or not the next cycle is a tick
         line_start_p0  <= 1'b0;
         frame_start_p0 <= 1'b0;
         if (vif.pix_en) begin
            hsync_p0       <= h_sync ? H_ON : ~H_ON;
            vsync_p0       <= v_sync ? V_ON : ~V_ON;
            de_p0          <= h_act & v_act;
            x_p0           <= (h_act & v_act) ? hc : '0;
            y_p0           <= (h_act & v_act) ? vc : '0;
            line_start_p0  <= sol;
            frame_start_p0 <= sof;
         end
      end
   end

   assign vif.hsync       = hsync_p0;
   assign vif.vsync       = vsync_p0;
   assign vif.de          = de_p0;
   assign vif.x           = x_p0;
   assign vif.y           = y_p0;
   assign vif.line_start  = line_start_p0;
   assign vif.frame_start = frame_start_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators run side by side from one pix_en/rst: the 640x480 default
// mode, the 800x600 mode with positive polarities, and a tiny 15x10 raster
// so whole frames fit in a short run. Every stimulus cycle pushes the
// expected registered outputs into a per-instance queue; a monitor pops and
// compares after each clock edge. Hand-computed tallies cover line/frame
// periods, sync widths and active-area sizes.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct {
      logic        hs;
      logic        vs;
      logic        de;
      logic [15:0] x;
      logic [15:0] y;
      logic        ls;
      logic        fs;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.H_W(10), .V_W(10)) if0 ();
   vga_timing_gen_if #(.H_W(11), .V_W(10)) if1 ();
   vga_timing_gen_if #(.H_W(4),  .V_W(4))  if2 ();

   vga_timing_gen u0 (.clk(clk), .rst(rst), .vif(if0));

   vga_timing_gen #(
      .H_ACTIVE(VGA_800X600_H.active), .H_FP(VGA_800X600_H.fp), .H_SYNC(VGA_800X600_H.sync),
      .H_BP(VGA_800X600_H.bp), .H_POL(VGA_800X600_H.pol),
      .V_ACTIVE(VGA_800X600_V.active), .V_FP(VGA_800X600_V.fp), .V_SYNC(VGA_800X600_V.sync),
      .V_BP(VGA_800X600_V.bp), .V_POL(VGA_800X600_V.pol)
   ) u1 (.clk(clk), .rst(rst), .vif(if1));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_POL(0),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .V_POL(0)
   ) u2 (.clk(clk), .rst(rst), .vif(if2));

   int HA[3] = '{640, 800, 8};
   int HF[3] = '{16,  40,  2};
   int HS[3] = '{96,  128, 3};
   int HB[3] = '{48,  88,  2};
   int HP[3] = '{0,   1,   0};
   int VA[3] = '{480, 600, 5};
   int VF[3] = '{10,  1,   1};
   int VS[3] = '{2,   4,   2};
   int VB[3] = '{33,  23,  2};
   int VP[3] = '{0,   1,   0};

   int   mh[3];
   int   mv[3];
   obs_t mout[3];
   obs_t q0[$];
   obs_t q1[$];
   obs_t q2[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cur_phase = 0;
   int phase = 0;
   int cyc = 0;
   int last_ls = -1;

   int t_ls0 = 0, t_hs0_low = 0, t_de0 = 0;
   int t_ls1 = 0, t_hs1_high = 0;
   int t_fs2 = 0, t_vs2_low = 0, t_de2 = 0;
   int n_intervals = 0;

   function automatic obs_t reset_obs(int k);
      obs_t o;
      o.hs = (HP[k] == 0);
      o.vs = (VP[k] == 0);
      o.de = 1'b0;
      o.x  = '0;
      o.y  = '0;
      o.ls = 1'b0;
      o.fs = 1'b0;
      return o;
   endfunction

   function automatic obs_t decode(int k, int h, int v);
      obs_t o;
      bit   hin, vin;
      hin  = (h >= HA[k] + HF[k]) && (h < HA[k] + HF[k] + HS[k]);
      vin  = (v >= VA[k] + VF[k]) && (v < VA[k] + VF[k] + VS[k]);
      o.hs = hin ? (HP[k] != 0) : (HP[k] == 0);
      o.vs = vin ? (VP[k] != 0) : (VP[k] == 0);
      o.de = (h < HA[k]) && (v < VA[k]);
      o.x  = o.de ? 16'(h) : 16'd0;
      o.y  = o.de ? 16'(v) : 16'd0;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
      return o;
   endfunction

   function automatic obs_t observe(int k);
      obs_t o;
      case (k)
         0: begin
            o.hs = if0.hsync; o.vs = if0.vsync; o.de = if0.de;
            o.x = 16'(if0.x); o.y = 16'(if0.y); o.ls = if0.line_start; o.fs = if0.frame_start;
         end
         1: begin
            o.hs = if1.hsync; o.vs = if1.vsync; o.de = if1.de;
            o.x = 16'(if1.x); o.y = 16'(if1.y); o.ls = if1.line_start; o.fs = if1.frame_start;
         end
         default: begin
            o.hs = if2.hsync; o.vs = if2.vsync; o.de = if2.de;
            o.x = 16'(if2.x); o.y = 16'(if2.y); o.ls = if2.line_start; o.fs = if2.frame_start;
         end
      endcase
      return o;
   endfunction

   task automatic chk_int(input string nm, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_obs(input int k, input obs_t g, input obs_t e);
      n_checks++;
      if (g.hs !== e.hs || g.vs !== e.vs || g.de !== e.de || g.x !== e.x ||
          g.y !== e.y || g.ls !== e.ls || g.fs !== e.fs) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL u%0d outputs cyc=%0d: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     k, cyc, g.hs, g.vs, g.de, g.x, g.y, g.ls, g.fs,
                     e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
      end
   endtask

   // one clk of stimulus; expected registered outputs go to the scoreboard
   task automatic drive(input logic r, input logic pe);
      @(negedge clk);
      rst        = r;
      if0.pix_en = pe;
      if1.pix_en = pe;
      if2.pix_en = pe;
      phase      = cur_phase;
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            mh[k]   = 0;
            mv[k]   = 0;
            mout[k] = reset_obs(k);
         end else if (pe) begin
            mout[k] = decode(k, mh[k], mv[k]);
            mh[k]++;
            if (mh[k] == HA[k] + HF[k] + HS[k] + HB[k]) begin
               mh[k] = 0;
               mv[k]++;
               if (mv[k] == VA[k] + VF[k] + VS[k] + VB[k]) mv[k] = 0;
            end
         end else begin
            mout[k].ls = 1'b0;
            mout[k].fs = 1'b0;
         end
      end
      q0.push_back(mout[0]);
      q1.push_back(mout[1]);
      q2.push_back(mout[2]);
   endtask

   // monitor: pops one expectation per instance after each clock edge
   initial begin
      obs_t g, e;
      bit   tick;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         tick = (rst === 1'b0) && (if0.pix_en === 1'b1);
         for (int k = 0; k < 3; k++) begin
            g = observe(k);
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); chk_obs(0, g, e); end
            if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); chk_obs(1, g, e); end
            if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); chk_obs(2, g, e); end
         end
         if (phase == 1 && tick) begin
            if (if0.line_start === 1'b1)  t_ls0++;
            if (if0.hsync === 1'b0)       t_hs0_low++;
            if (if0.de === 1'b1)          t_de0++;
            if (if1.line_start === 1'b1)  t_ls1++;
            if (if1.hsync === 1'b1)       t_hs1_high++;
            if (if2.frame_start === 1'b1) t_fs2++;
            if (if2.vsync === 1'b0)       t_vs2_low++;
            if (if2.de === 1'b1)          t_de2++;
         end
         if (phase == 2 && if0.line_start === 1'b1) begin
            if (last_ls >= 0) begin
               chk_int("line period in clks at half-rate ticks", cyc - last_ls, 1600);
               n_intervals++;
            end
            last_ls = cyc;
         end
      end
   end

   initial begin
      int g;
      int w;
      rst        = 1'b1;
      if0.pix_en = 1'b0;
      if1.pix_en = 1'b0;
      if2.pix_en = 1'b0;

      // reset, including one cycle where pix_en is also high
      cur_phase = 0;
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);

      // continuous ticks: 2200 ticks from (0,0)
      cur_phase = 1;
      repeat (2200) drive(1'b0, 1'b1);

      // half-rate ticks: 1,0,1,0 ...
      cur_phase = 2;
      for (int i = 0; i < 3400; i++) drive(1'b0, (i % 2) == 0);

      // run to column 300 of a line, then reset mid-frame
      cur_phase = 3;
      g = 0;
      while (mh[0] != 300 && g < 3000) begin
         drive(1'b0, 1'b1);
         g++;
      end
      chk_int("reached column 300 before mid-frame reset", mh[0], 300);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      repeat (200) drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);

      w = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && w < 10) begin
         @(posedge clk);
         #2;
         w++;
      end
      chk_int("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);

      chk_int("640x480 line_start count over 2200 ticks", t_ls0, 3);
      chk_int("640x480 hsync low ticks over 2200 ticks", t_hs0_low, 192);
      chk_int("640x480 de ticks over 2200 ticks", t_de0, 1880);
      chk_int("800x600 line_start count over 2200 ticks", t_ls1, 3);
      chk_int("800x600 hsync high ticks over 2200 ticks", t_hs1_high, 256);
      chk_int("15x10 frame_start count over 2200 ticks", t_fs2, 15);
      chk_int("15x10 vsync low ticks over 2200 ticks", t_vs2_low, 430);
      chk_int("15x10 de ticks over 2200 ticks", t_de2, 600);
      chk_int("half-rate line intervals seen", n_intervals, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
